axi4_stream_initiator_arbiter: RTL

Packet-level round-robin arbiter that shares one NoC AXI4-Stream initiator port between `NumInitiators` traffic sources, such as `axi4_stream_initiator_type_1` instances. A grant is held from the first accepted transfer of a packet until its `tlast` transfer, so packets are never interleaved. The output goes through a one-entry register slice toward the NoC or an `axi4_stream_target_type_1`. A sticky error flag reports a `tid`/`tdest` change inside a packet.

---
 rtl/axi4_stream_arbiter_pkg.sv | 35 +++
 rtl/axi4_stream_register_slice.sv | 47 ++++
 rtl/axi4_stream_initiator_arbiter.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/axi4_stream_arbiter_pkg.sv
// Shared types and helpers for AXI4-Stream arbiters.
// Contents: arb_state_t (IDLE/LOCKED), width limits, rr_pick round-robin picker.
package axi4_stream_arbiter_pkg;

  localparam int unsigned MaxInitiators = 16;
  localparam int unsigned PtrWidth      = 4;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  // One-hot pick of the first set request at or above ptr, wrapping modulo n.
  // Requests above n-1 must be zero; n defaults to the widest supported arbiter.
  function automatic logic [MaxInitiators-1:0] rr_pick(
    input logic [MaxInitiators-1:0] req,
    input logic [PtrWidth-1:0]      ptr,
    input int unsigned              n = MaxInitiators
  );
    logic [MaxInitiators-1:0] grant;
    logic                     found;
    logic [PtrWidth-1:0]      idx;
    grant = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < MaxInitiators; k++) begin
      idx = PtrWidth'((32'(ptr) + k) % n);
      if ((k < n) && !found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
    return grant;
  endfunction

endpackage

// File: rtl/axi4_stream_register_slice.sv
// One-entry AXI4-Stream register slice.
// Ports: clk/rst_n (async active-low); in_* upstream beat with in_ready_c
// (combinational, depends only on out_valid/out_ready); out_* registered beat.
module axi4_stream_register_slice #(
  parameter int unsigned TDataWidth = 32,
  parameter int unsigned TIdWidth   = 8,
  parameter int unsigned TDestWidth = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready_c,
  input  logic [TDataWidth-1:0] in_data,
  input  logic                  in_last,
  input  logic [TIdWidth-1:0]   in_id,
  input  logic [TDestWidth-1:0] in_dest,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [TDataWidth-1:0] out_data,
  output logic                  out_last,
  output logic [TIdWidth-1:0]   out_id,
  output logic [TDestWidth-1:0] out_dest
);

  // Free when empty or draining this cycle.
  assign in_ready_c = !out_valid || out_ready;

  // Load on handshake; otherwise hold data and clear valid once drained.
  always_ff @(posedge clk or negedge rst_n) begin : slice_reg
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_id    <= '0;
      out_dest  <= '0;
    end else if (in_valid && in_ready_c) begin
      out_valid <= 1'b1;
      out_data  <= in_data;
      out_last  <= in_last;
      out_id    <= in_id;
      out_dest  <= in_dest;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/axi4_stream_initiator_arbiter.sv
// Packet-level round-robin arbiter sharing one AXI4-Stream port among NumInitiators.
// Ports: clk_axis_i/rst_axis_ni (async active-low); s_axis_* per-initiator inputs
// (vectors sliced per initiator); m_axis_* registered shared output; grant_o
// one-hot held for a whole packet; arb_error_o sticky tid/tdest-change flag.
module axi4_stream_initiator_arbiter
  import axi4_stream_arbiter_pkg::*;
#(
  parameter int unsigned NumInitiators = 4,
  parameter int unsigned TDataWidth    = 32,
  parameter int unsigned TIdWidth      = 8,
  parameter int unsigned TDestWidth    = 8
) (
  input  logic                               clk_axis_i,
  input  logic                               rst_axis_ni,
  input  logic [NumInitiators-1:0]           s_axis_tvalid_i,
  output logic [NumInitiators-1:0]           s_axis_tready_o,
  input  logic [NumInitiators*TDataWidth-1:0] s_axis_tdata_i,
  input  logic [NumInitiators-1:0]           s_axis_tlast_i,
  input  logic [NumInitiators*TIdWidth-1:0]   s_axis_tid_i,
  input  logic [NumInitiators*TDestWidth-1:0] s_axis_tdest_i,
  output logic                               m_axis_tvalid_o,
  input  logic                               m_axis_tready_i,
  output logic [TDataWidth-1:0]              m_axis_tdata_o,
  output logic                               m_axis_tlast_o,
  output logic [TIdWidth-1:0]                m_axis_tid_o,
  output logic [TDestWidth-1:0]              m_axis_tdest_o,
  output logic [NumInitiators-1:0]           grant_o,
  output logic                               arb_error_o
);

  localparam int unsigned IdxWidth = (NumInitiators > 1) ? $clog2(NumInitiators) : 1;

  arb_state_t               state_q, state_d;
  logic [IdxWidth-1:0]      rr_ptr_q, grant_idx, next_ptr;
  logic                     sel_valid, sel_last;
  logic [TDataWidth-1:0]    sel_data;
  logic [TIdWidth-1:0]      sel_id, ref_id_q;
  logic [TDestWidth-1:0]    sel_dest, ref_dest_q;
  logic                     slice_in_valid, slice_in_ready, accept;
  logic                     first_q;
  logic [MaxInitiators-1:0] pick_wide;
  logic [NumInitiators-1:0] pick;
  logic                     unused_pick_hi;

  // Round-robin candidate for the next packet.
  assign pick_wide      = rr_pick(MaxInitiators'(s_axis_tvalid_i), PtrWidth'(rr_ptr_q), NumInitiators);
  assign pick           = pick_wide[NumInitiators-1:0];
  assign unused_pick_hi = ^pick_wide;

  // Input mux steered by the held one-hot grant.
  always_comb begin : input_mux
    grant_idx = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    sel_id    = '0;
    sel_dest  = '0;
    for (int unsigned i = 0; i < NumInitiators; i++) begin
      if (grant_o[i]) begin
        grant_idx = IdxWidth'(i);
        sel_valid = s_axis_tvalid_i[i];
        sel_last  = s_axis_tlast_i[i];
        sel_data  = s_axis_tdata_i[i*TDataWidth +: TDataWidth];
        sel_id    = s_axis_tid_i[i*TIdWidth +: TIdWidth];
        sel_dest  = s_axis_tdest_i[i*TDestWidth +: TDestWidth];
      end
    end
  end

  assign next_ptr = (grant_idx == IdxWidth'(NumInitiators - 1)) ? '0
                                                                 : grant_idx + IdxWidth'(1);

  // FSM state register.
  always_ff @(posedge clk_axis_i or negedge rst_axis_ni) begin : fsm_state
    if (!rst_axis_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: lock on any request, release after the tlast beat.
  always_comb begin : fsm_next
    state_d = state_q;
    case (state_q)
      IDLE:    if (|s_axis_tvalid_i) state_d = LOCKED;
      LOCKED:  if (accept && sel_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: only the granted input sees the slice's ready.
  always_comb begin : fsm_out
    slice_in_valid  = 1'b0;
    s_axis_tready_o = '0;
    if (state_q == LOCKED) begin
      slice_in_valid  = sel_valid;
      s_axis_tready_o = slice_in_ready ? grant_o : '0;
    end
  end

  assign accept = slice_in_valid && slice_in_ready;

  // Grant, round-robin pointer and in-packet tid/tdest consistency check.
  always_ff @(posedge clk_axis_i or negedge rst_axis_ni) begin : arb_reg
    if (!rst_axis_ni) begin
      grant_o     <= '0;
      rr_ptr_q    <= '0;
      first_q     <= 1'b0;
      ref_id_q    <= '0;
      ref_dest_q  <= '0;
      arb_error_o <= 1'b0;
    end else begin
      if (state_q == IDLE) begin
        grant_o <= pick;
        first_q <= 1'b1;
      end else if (accept && sel_last) begin
        grant_o  <= '0;
        rr_ptr_q <= next_ptr;
      end
      if (accept) begin
        first_q <= 1'b0;
        if (first_q) begin
          ref_id_q   <= sel_id;
          ref_dest_q <= sel_dest;
        end else if ((sel_id != ref_id_q) || (sel_dest != ref_dest_q)) begin
          arb_error_o <= 1'b1;
        end
      end
    end
  end

  axi4_stream_register_slice #(
    .TDataWidth (TDataWidth),
    .TIdWidth   (TIdWidth),
    .TDestWidth (TDestWidth)
  ) u_slice (
    .clk        (clk_axis_i),
    .rst_n      (rst_axis_ni),
    .in_valid   (slice_in_valid),
    .in_ready_c (slice_in_ready),
    .in_data    (sel_data),
    .in_last    (sel_last),
    .in_id      (sel_id),
    .in_dest    (sel_dest),
    .out_valid  (m_axis_tvalid_o),
    .out_ready  (m_axis_tready_i),
    .out_data   (m_axis_tdata_o),
    .out_last   (m_axis_tlast_o),
    .out_id     (m_axis_tid_o),
    .out_dest   (m_axis_tdest_o)
  );

endmodule
